seq_mul_nb: RTL and testbench
=============================

Name: seq_mul_nb

Overview:
- Parametrised, iterative shift-add multiplier for WIDTH-bit operands, producing a 2*WIDTH-bit product.
- Supports unsigned and two's-complement signed modes, selected per operation.
- Valid/ready handshakes on input and output, so it can sit between pipeline stages of the datapath.
- Trades latency for area: one partial-product bit per cycle, one multiplication in flight.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32. Product width is 2*WIDTH.
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter. Derived; do not override.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- in_valid  input  1  operands and mode are valid this cycle.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  1 = two's-complement operands and product; 0 = unsigned.
- out_valid  output  1  product is valid; held until consumed.
- out_ready  input  1  downstream accepts the product.
- p  output  2*WIDTH  product.

Behaviour:
- Reset (async assert, synchronous release by design convention):
  - state = IDLE; in_ready = 1; out_valid = 0; p = 0.
  - accumulator, operand registers, sign flag and counter = 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture |a| and |b| into internal WIDTH-bit registers.
    - Magnitude = two's-complement negate if signed_mode and MSB = 1; otherwise the raw value.
    - -2^(WIDTH-1) gives magnitude 2^(WIDTH-1), which fits unsigned.
  - Store neg = signed_mode & (a[MSB] ^ b[MSB]); clear accumulator; counter = WIDTH; go BUSY.
- BUSY:
  - in_ready = 0.
  - Each cycle: if multiplier LSB = 1, accumulator += multiplicand << (WIDTH - counter). Shift-register implementation is equivalent.
  - Then shift the multiplier right 1 and decrement the counter.
  - When the counter reaches 0 on an edge, transition to DONE.
  - On that same edge, load p = neg ? (~acc + 1) truncated to 2*WIDTH : acc.
- DONE:
  - out_valid = 1; p is stable.
  - On out_valid & out_ready, go IDLE. out_valid drops and in_ready rises on the following cycle.
  - p keeps its value after consumption until the next DONE load.
- Latency:
  - Accept edge at T0; out_valid is high after edge T0+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles: accept, WIDTH BUSY edges, one DONE handshake cycle.
- Backpressure: out_ready low in DONE holds state, p and out_valid indefinitely. No new input is accepted.
- in_valid is ignored outside IDLE. Operands presented in BUSY/DONE are not captured and not queued.
- Operand inputs are sampled only on the accept edge; changes afterwards do not affect the result.
- Zero operands: no early termination. Latency is always exactly WIDTH.
- Arithmetic:
  - Product is exact in 2*WIDTH bits for all operand pairs in both modes. No overflow is possible.
  - Signed corner: (-2^(W-1)) * (-2^(W-1)) = 2^(2W-2), positive, fits.
- Reset mid-operation (BUSY or DONE):
  - Aborts immediately; no out_valid pulse for the aborted operation.
  - After release, the block is in IDLE with all reset values.

Test Plan:
- WIDTH=8, unsigned, a=0xFF b=0xFF -> after exactly 8 edges out_valid=1, p=0xFE01; in_ready=0 throughout BUSY/DONE.
- WIDTH=8, signed:
  - 0x80*0x80 -> p=0x4000.
  - 0x80*0x7F -> p=0xC080.
  - 0xFF*0x01 -> p=0xFFFF.
  - Same 0xFF*0x01 unsigned -> p=0x00FF.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> p and out_valid stable and in_ready=0. Raise out_ready for 1 cycle -> out_valid=0 and in_ready=1 next cycle.
- Back-to-back: in_valid held high with changing operands -> exactly one capture per IDLE visit; results match operands at each accept edge; issue interval = 10 cycles.
- Reset asserted at BUSY cycle 3 with a=0x12 b=0x34 -> all outputs at reset values immediately (async). Next op 0x03*0x05 -> p=0x000F with no stale accumulation.
- WIDTH=4, exhaustive 256 pairs in both modes -> p matches the golden model (a*b, sign-extended as appropriate) with latency 4 for every pair.

Source files
------------

// File: rtl/seq_mul_nb.sv
// seq_mul_nb: iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Signed mode multiplies magnitudes and negates the result at the end.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE
// and stays high, with p stable, until a cycle with out_ready high. Neither
// ready depends combinationally on the opposite valid.
module seq_mul_nb #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_acc;
   logic                 r_neg;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_p;
   logic                 r_in_ready;
   logic                 r_out_valid;

   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic                 w_neg_in;
   logic [2*WIDTH-1:0]   w_acc_next;
   logic [2*WIDTH-1:0]   w_prod;

   // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which
   // still fits in an unsigned WIDTH-bit register.
   always_comb begin
      w_mag_a  = (signed_mode & a[WIDTH-1]) ? (~a + 1'b1) : a;
      w_mag_b  = (signed_mode & b[WIDTH-1]) ? (~b + 1'b1) : b;
      w_neg_in = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
   end

   // One partial product per cycle; the multiplicand is pre-shifted so the
   // add position follows the iteration count.
   always_comb begin
      w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {2*WIDTH{1'b0}});
      w_prod     = r_neg ? (~w_acc_next + 1'b1) : w_acc_next;
   end

   // Control FSM and datapath registers, all outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_acc       <= '0;
         r_neg       <= 1'b0;
         r_cnt       <= '0;
         r_p         <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_mcand    <= {{WIDTH{1'b0}}, w_mag_a};
                  r_mplier   <= w_mag_b;
                  r_neg      <= w_neg_in;
                  r_acc      <= '0;
                  r_cnt      <= CNT_W'(WIDTH);
                  r_in_ready <= 1'b0;
                  r_state    <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt - 1'b1;
               if (r_cnt == CNT_W'(1)) begin
                  r_p         <= w_prod;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (r_out_valid && out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign p         = r_p;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_mul_nb.sv
// Bench for seq_mul_nb: directed WIDTH=8 vectors, multi-cycle corner
// sequences, and an exhaustive WIDTH=4 sweep against an integer model.
module tb_seq_mul_nb;

   logic clk;
   logic reset;

   logic        in_valid8, in_ready8, s8, out_valid8, out_ready8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic [1:0]  st8;

   logic        in_valid4, in_ready4, s4, out_valid4, out_ready4;
   logic [3:0]  a4, b4;
   logic [7:0]  p4;
   logic [1:0]  st4;

   int n_vec = 0;
   int n_err = 0;
   logic [15:0] exp_q[$];

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        s;
      logic [15:0] p;
   } vec_t;
   vec_t vecs[12];

   seq_mul_nb #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .signed_mode(s8), .out_valid(out_valid8),
      .out_ready(out_ready8), .p(p8), .dbg_state(st8)
   );

   seq_mul_nb #(.WIDTH(4)) u_dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .signed_mode(s4), .out_valid(out_valid4),
      .out_ready(out_ready4), .p(p4), .dbg_state(st4)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // driver: one WIDTH=8 operation; returns at the first cycle out_valid is high
   task automatic run_op8(input logic [7:0] ia, input logic [7:0] ib, input logic is,
                          output logic [15:0] pr, output int lat, output logic busy_ok);
      int guard = 0;
      while (!in_ready8 && guard < 100) begin
         @(posedge clk); #1; guard++;
      end
      if (guard >= 100) check("ready8_timeout", 32'(guard), 0);
      a8 = ia; b8 = ib; s8 = is; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      a8 = ~ia; b8 = ~ib; s8 = ~is;
      lat = 0; busy_ok = 1'b1;
      while (!out_valid8 && lat < 100) begin
         if (in_ready8) busy_ok = 1'b0;
         @(posedge clk); #1; lat++;
      end
      if (in_ready8) busy_ok = 1'b0;
      pr = p8;
   endtask

   task automatic run_op4(input logic [3:0] ia, input logic [3:0] ib, input logic is,
                          output logic [7:0] pr, output int lat);
      int guard = 0;
      while (!in_ready4 && guard < 100) begin
         @(posedge clk); #1; guard++;
      end
      if (guard >= 100) check("ready4_timeout", 32'(guard), 0);
      a4 = ia; b4 = ib; s4 = is; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      a4 = ~ia; b4 = ~ib;
      lat = 0;
      while (!out_valid4 && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      pr = p4;
   endtask

   initial begin
      logic [15:0] pr;
      logic [7:0]  pr4;
      int          lat;
      logic        busy_ok;
      logic        stable;
      logic        prev_ov;
      int          last_acc;
      int          n_res;
      logic        no_pulse;

      vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
      vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
      vecs[2]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
      vecs[3]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
      vecs[4]  = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
      vecs[5]  = '{8'h00, 8'h00, 1'b0, 16'h0000};
      vecs[6]  = '{8'h12, 8'h34, 1'b0, 16'h03A8};
      vecs[7]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
      vecs[8]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
      vecs[9]  = '{8'h03, 8'h05, 1'b0, 16'h000F};
      vecs[10] = '{8'h05, 8'hFD, 1'b1, 16'hFFF1};
      vecs[11] = '{8'h80, 8'h02, 1'b0, 16'h0100};

      reset = 1'b1;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; out_ready8 = 1'b1;
      in_valid4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; out_ready4 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready8), 1);
      check("rst_out_valid", 32'(out_valid8), 0);
      check("rst_p", 32'(p8), 0);
      check("rst_state", 32'(st8), 0);
      check("rst_in_ready4", 32'(in_ready4), 1);
      check("rst_p4", 32'(p4), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // directed table
      for (int i = 0; i < 12; i++) begin
         run_op8(vecs[i].a, vecs[i].b, vecs[i].s, pr, lat, busy_ok);
         check($sformatf("vec%0d_p", i), 32'(pr), 32'(vecs[i].p));
         check($sformatf("vec%0d_latency", i), 32'(lat), 8);
         check($sformatf("vec%0d_in_ready_low", i), 32'(busy_ok), 1);
      end
      @(posedge clk); #1;

      // backpressure: DONE held for 20 cycles, in_valid offered and ignored
      out_ready8 = 1'b0;
      run_op8(8'h5A, 8'hC3, 1'b0, pr, lat, busy_ok);
      check("bp_p", 32'(pr), 32'h448E);
      check("bp_latency", 32'(lat), 8);
      stable = 1'b1;
      a8 = 8'h11; b8 = 8'h22; s8 = 1'b0; in_valid8 = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (p8 !== 16'h448E || out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || st8 !== 2'd2)
            stable = 1'b0;
      end
      check("bp_hold_stable", 32'(stable), 1);
      in_valid8 = 1'b0;
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      check("bp_release_out_valid", 32'(out_valid8), 0);
      check("bp_release_in_ready", 32'(in_ready8), 1);
      check("bp_p_retained", 32'(p8), 32'h448E);
      @(posedge clk); #1;
      check("bp_no_capture", 32'(in_ready8), 1);
      out_ready8 = 1'b1;

      // back-to-back: in_valid held high, operands change every cycle
      last_acc = -1; n_res = 0; prev_ov = out_valid8;
      in_valid8 = 1'b1; s8 = 1'b0;
      for (int c = 0; c < 50; c++) begin
         a8 = 8'(c * 7 + 3);
         b8 = 8'(c * 13 + 1);
         if (in_ready8) begin
            exp_q.push_back(16'(a8) * 16'(b8));
            if (last_acc >= 0) check("b2b_interval", 32'(c - last_acc), 10);
            last_acc = c;
         end
         @(posedge clk); #1;
         if (out_valid8 && !prev_ov) begin
            if (exp_q.size() == 0) check("b2b_spurious_result", 1, 0);
            else check("b2b_p", 32'(p8), 32'(exp_q.pop_front()));
            n_res++;
         end
         prev_ov = out_valid8;
      end
      in_valid8 = 1'b0;
      check("b2b_result_count", 32'(n_res), 5);
      check("b2b_queue_empty", 32'(exp_q.size()), 0);
      @(posedge clk); #1;

      // async reset during BUSY, then a clean operation
      a8 = 8'h12; b8 = 8'h34; s8 = 1'b0; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("midrst_busy_before", 32'(st8), 1);
      reset = 1'b1;
      #1;
      check("midrst_in_ready", 32'(in_ready8), 1);
      check("midrst_out_valid", 32'(out_valid8), 0);
      check("midrst_p", 32'(p8), 0);
      check("midrst_state", 32'(st8), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      no_pulse = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (out_valid8) no_pulse = 1'b0;
         @(posedge clk); #1;
      end
      check("midrst_no_out_valid", 32'(no_pulse), 1);
      run_op8(8'h03, 8'h05, 1'b0, pr, lat, busy_ok);
      check("midrst_next_p", 32'(pr), 32'h000F);
      check("midrst_next_latency", 32'(lat), 8);
      @(posedge clk); #1;

      // exhaustive WIDTH=4 in both modes
      for (int m = 0; m < 2; m++) begin
         for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
               int sa;
               int sb;
               logic [7:0] e;
               sa = (m == 1 && x >= 8) ? x - 16 : x;
               sb = (m == 1 && y >= 8) ? y - 16 : y;
               e  = 8'(sa * sb);
               run_op4(4'(x), 4'(y), 1'(m), pr4, lat);
               check($sformatf("w4_m%0d_%0h_%0h_p", m, x, y), 32'(pr4), 32'(e));
               check($sformatf("w4_m%0d_%0h_%0h_latency", m, x, y), 32'(lat), 4);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
